// File: rtl/spi_rom_burst_fetcher_if.sv
// Bundle of request, display and SPI pad signals for the burst fetcher.
// The slave side is the fetcher; the master side is the requester or bench.
interface spi_rom_burst_fetcher_if;
   logic        req;
   logic [23:0] req_addr;
   logic        busy;
   logic        done;
   logic        swap;
   logic        shift_en;
   logic        pixel_out;
   logic        spi_cs;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;

   // Handshake: req is a one-cycle pulse taken only while busy=0; busy stays
   // high until the cycle in which done pulses, and req may be reissued then.
   modport slave (
      input  req, req_addr, swap, shift_en, spi_miso,
      output busy, done, pixel_out, spi_cs, spi_sclk, spi_mosi
   );

   modport master (
      output req, req_addr, swap, shift_en, spi_miso,
      input  busy, done, pixel_out, spi_cs, spi_sclk, spi_mosi
   );
endinterface

// File: rtl/spi_rom_burst_fetcher.sv
// Double-buffered SPI flash burst reader: fetches BUFFER_DEPTH bits into the
// back bank while the pixel logic shifts the front bank out.
module spi_rom_burst_fetcher #(
   parameter int BUFFER_DEPTH = 128,
   parameter int DUMMY_CYCLES = 0,
   parameter int MISO_LAG     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   spi_rom_burst_fetcher_if.slave  bus,
   output logic [2:0]              dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_ADDR  = 3'd2,
      S_DUMMY = 3'd3,
      S_DATA  = 3'd4
   } state_t;

   localparam int              CW         = $clog2(BUFFER_DEPTH + MISO_LAG + DUMMY_CYCLES + 33);
   localparam logic [7:0]      CMD_BYTE   = (DUMMY_CYCLES == 0) ? 8'h03 : 8'h0B;
   localparam logic [CW-1:0]   CMD_LAST   = CW'(7);
   localparam logic [CW-1:0]   ADDR_LAST  = CW'(23);
   localparam logic [CW-1:0]   DUMMY_LAST = CW'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
   localparam logic [CW-1:0]   DATA_LAST  = CW'(BUFFER_DEPTH + MISO_LAG - 1);
   localparam logic [CW-1:0]   LAG_C      = CW'(MISO_LAG);

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [31:0]             sh_q, sh_d;
   logic                    bank_q, bank_d;
   logic [BUFFER_DEPTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic                    done_q, done_d;

   logic busy;
   logic accept;
   logic swap_ok;
   logic capture;
   logic mosi;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts cycles within the current phase and restarts at every phase change.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.req) state_d = S_CMD;
         end
         S_CMD: if (cnt_q == CMD_LAST) begin
            state_d = S_ADDR;
            cnt_d   = '0;
         end
         S_ADDR: if (cnt_q == ADDR_LAST) begin
            state_d = (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
            cnt_d   = '0;
         end
         S_DUMMY: if (cnt_q == DUMMY_LAST) begin
            state_d = S_DATA;
            cnt_d   = '0;
         end
         S_DATA: if (cnt_q == DATA_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The first MISO_LAG data cycles only drain the pad pipeline, so capture waits.
   always_comb begin
      busy    = (state_q != S_IDLE);
      accept  = (state_q == S_IDLE) && bus.req;
      swap_ok = !busy && bus.swap;
      capture = (state_q == S_DATA) && ((cnt_q + CW'(1)) > LAG_C);
      done_d  = (state_q == S_DATA) && (cnt_q == DATA_LAST);
      mosi    = ((state_q == S_CMD) || (state_q == S_ADDR)) && sh_q[31];
   end

   always_comb begin
      sh_d   = sh_q;
      bank_d = bank_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      if (accept) begin
         sh_d = {CMD_BYTE, bus.req_addr};
      end else if ((state_q == S_CMD) || (state_q == S_ADDR)) begin
         sh_d = {sh_q[30:0], 1'b0};
      end
      // Swap beats shift; capture only happens while busy, so never alongside a swap.
      if (swap_ok) begin
         bank_d = ~bank_q;
      end else if (bus.shift_en) begin
         if (bank_q) buf1_d = {buf1_q[BUFFER_DEPTH-2:0], 1'b0};
         else        buf0_d = {buf0_q[BUFFER_DEPTH-2:0], 1'b0};
      end
      if (capture) begin
         if (bank_q) buf0_d = {buf0_q[BUFFER_DEPTH-2:0], bus.spi_miso};
         else        buf1_d = {buf1_q[BUFFER_DEPTH-2:0], bus.spi_miso};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q   <= '0;
         bank_q <= 1'b0;
         buf0_q <= '0;
         buf1_q <= '0;
         done_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         bank_q <= bank_d;
         buf0_q <= buf0_d;
         buf1_q <= buf1_d;
         done_q <= done_d;
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done_q;
   assign bus.spi_cs    = busy;
   assign bus.spi_mosi  = mosi;
   assign bus.spi_sclk  = ~clk;
   assign bus.pixel_out = bank_q ? buf1_q[BUFFER_DEPTH-1] : buf0_q[BUFFER_DEPTH-1];
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_rom_burst_fetcher.sv
// Bench for spi_rom_burst_fetcher: three parameterisations driven in lockstep,
// checked against a cycle-indexed burst model plus hand-computed spot vectors.
module tb_spi_rom_burst_fetcher;
   localparam int ND    = 3;
   localparam int D_MAX = 128;

   logic        clk = 1'b0;
   logic        rst_s;
   logic        req_s;
   logic [23:0] addr_s;
   logic        swap_s;
   logic        shift_s;
   logic        miso_s [ND];
   logic [2:0]  dbg0, dbg1, dbg2;

   always #5 clk = ~clk;

   spi_rom_burst_fetcher_if b0 ();
   spi_rom_burst_fetcher_if b1 ();
   spi_rom_burst_fetcher_if b2 ();

   assign b0.req = req_s;  assign b0.req_addr = addr_s;  assign b0.swap = swap_s;
   assign b0.shift_en = shift_s;  assign b0.spi_miso = miso_s[0];
   assign b1.req = req_s;  assign b1.req_addr = addr_s;  assign b1.swap = swap_s;
   assign b1.shift_en = shift_s;  assign b1.spi_miso = miso_s[1];
   assign b2.req = req_s;  assign b2.req_addr = addr_s;  assign b2.swap = swap_s;
   assign b2.shift_en = shift_s;  assign b2.spi_miso = miso_s[2];

   spi_rom_burst_fetcher #(.BUFFER_DEPTH(128), .DUMMY_CYCLES(0), .MISO_LAG(0)) u0 (
      .clk(clk), .reset(rst_s), .bus(b0.slave), .dbg_state(dbg0));
   spi_rom_burst_fetcher #(.BUFFER_DEPTH(128), .DUMMY_CYCLES(8), .MISO_LAG(0)) u1 (
      .clk(clk), .reset(rst_s), .bus(b1.slave), .dbg_state(dbg1));
   spi_rom_burst_fetcher #(.BUFFER_DEPTH(128), .DUMMY_CYCLES(0), .MISO_LAG(1)) u2 (
      .clk(clk), .reset(rst_s), .bus(b2.slave), .dbg_state(dbg2));

   int cfg_d  [ND] = '{128, 128, 128};
   int cfg_dc [ND] = '{0, 8, 0};
   int cfg_ml [ND] = '{0, 0, 1};

   // Reference model: burst cycle index (-1 when idle), latched address,
   // displayed bank, and each bank as received-order bits plus a read position.
   int          m_c     [ND];
   logic [23:0] m_addr  [ND];
   bit          m_front [ND];
   bit          m_bank  [ND][2][D_MAX];
   int          m_pos   [ND][2];
   logic [7:0]  flash_mem [256];

   typedef struct {
      int         k;
      int         cyc;
      logic [3:0] want;   // {cs, busy, done, mosi}
   } spot_t;
   spot_t spots [18];

   int n_checks = 0;
   int n_err    = 0;
   int scen_c   = -1;
   bit chk_en   = 1'b0;

   function automatic int m_p(input int k);
      return 32 + cfg_dc[k];
   endfunction

   function automatic int m_l(input int k);
      return 32 + cfg_dc[k] + cfg_d[k] + cfg_ml[k];
   endfunction

   function automatic bit flash_bit(input logic [23:0] a, input int j);
      logic [7:0] b;
      int         idx;
      idx = (int'(a[7:0]) + j / 8) % 256;
      b   = flash_mem[idx];
      return b[7 - (j % 8)];
   endfunction

   function automatic logic [5:0] exp_out(input int k);
      int          c;
      logic [7:0]  cmd;
      logic [31:0] word;
      logic        cs, done, mosi, pix;
      int          f;
      c    = m_c[k];
      cmd  = (cfg_dc[k] > 0) ? 8'h0B : 8'h03;
      word = {cmd, m_addr[k]};
      cs   = (c >= 0) && (c < m_l(k));
      done = (c == m_l(k));
      mosi = (cs && c < 32) ? word[31 - c] : 1'b0;
      f    = int'(m_front[k]);
      pix  = (m_pos[k][f] < cfg_d[k]) ? m_bank[k][f][m_pos[k][f]] : 1'b0;
      return {cs, cs, done, mosi, pix, cs};
   endfunction

   function automatic logic [5:0] dut_out(input int k);
      case (k)
         0:       return {b0.spi_cs, b0.busy, b0.done, b0.spi_mosi, b0.pixel_out, dbg0 != 3'd0};
         1:       return {b1.spi_cs, b1.busy, b1.done, b1.spi_mosi, b1.pixel_out, dbg1 != 3'd0};
         default: return {b2.spi_cs, b2.busy, b2.done, b2.spi_mosi, b2.pixel_out, dbg2 != 3'd0};
      endcase
   endfunction

   task automatic model_update(input int k, input logic r, input logic [23:0] a,
                               input logic sw, input logic sh);
      bit busy_now;
      int f, nb;
      busy_now = (m_c[k] >= 0) && (m_c[k] < m_l(k));
      if (rst_s) begin
         m_c[k]     = -1;
         m_front[k] = 1'b0;
         for (int b = 0; b < 2; b++) begin
            m_pos[k][b] = 0;
            for (int j = 0; j < D_MAX; j++) m_bank[k][b][j] = 1'b0;
         end
         return;
      end
      f = int'(m_front[k]);
      if (sw && !busy_now) m_front[k] = ~m_front[k];
      else if (sh && m_pos[k][f] < 100000) m_pos[k][f] = m_pos[k][f] + 1;
      if (m_c[k] == m_l(k) - 1) begin
         nb = 1 - int'(m_front[k]);
         for (int j = 0; j < cfg_d[k]; j++) m_bank[k][nb][j] = flash_bit(m_addr[k], j);
         m_pos[k][nb] = 0;
      end
      if (busy_now) begin
         m_c[k] = m_c[k] + 1;
      end else if (r) begin
         m_c[k]    = 0;
         m_addr[k] = a;
      end else begin
         m_c[k] = -1;
      end
   endtask

   // One clock cycle: drive inputs and MISO, check outputs, advance the model.
   task automatic step(input logic r, input logic [23:0] a, input logic sw, input logic sh);
      logic [5:0] got, exp;
      logic [3:0] got4;
      int         c;
      req_s = r;  addr_s = a;  swap_s = sw;  shift_s = sh;
      for (int k = 0; k < ND; k++) begin
         c = m_c[k];
         if (c >= m_p(k) + cfg_ml[k] && c < m_l(k))
            miso_s[k] = flash_bit(m_addr[k], c - m_p(k) - cfg_ml[k]);
         else
            miso_s[k] = 1'($urandom_range(0, 1));
      end
      if (chk_en) begin
         for (int k = 0; k < ND; k++) begin
            got = dut_out(k);
            exp = exp_out(k);
            n_checks++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL outputs dut%0d t=%0t got=%b want=%b (cs,busy,done,mosi,pix,active)",
                        k, $time, got, exp);
            end
         end
         if (scen_c >= 0) begin
            for (int i = 0; i < 18; i++) begin
               if (spots[i].cyc == scen_c) begin
                  got  = dut_out(spots[i].k);
                  got4 = got[5:2];
                  n_checks++;
                  if (got4 !== spots[i].want) begin
                     n_err++;
                     $display("FAIL spot dut%0d cyc%0d got=%b want=%b (cs,busy,done,mosi)",
                              spots[i].k, scen_c, got4, spots[i].want);
                  end
               end
            end
         end
      end
      @(posedge clk);
      for (int k = 0; k < ND; k++) model_update(k, r, a, sw, sh);
      #1;
   endtask

   task automatic idle(input int n, input logic sh);
      for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b0, sh);
   endtask

   initial begin
      logic [7:0] pat;
      logic       got_pix, want_pix;
      logic [5:0] o;

      spots[0]  = '{0, 0,   4'b1100};  spots[1]  = '{0, 5,   4'b1100};
      spots[2]  = '{0, 6,   4'b1101};  spots[3]  = '{0, 7,   4'b1101};
      spots[4]  = '{0, 23,  4'b1101};  spots[5]  = '{0, 24,  4'b1100};
      spots[6]  = '{0, 25,  4'b1101};  spots[7]  = '{0, 27,  4'b1101};
      spots[8]  = '{0, 31,  4'b1100};  spots[9]  = '{0, 159, 4'b1100};
      spots[10] = '{0, 160, 4'b0010};  spots[11] = '{1, 4,   4'b1101};
      spots[12] = '{1, 5,   4'b1100};  spots[13] = '{1, 35,  4'b1100};
      spots[14] = '{1, 167, 4'b1100};  spots[15] = '{1, 168, 4'b0010};
      spots[16] = '{2, 160, 4'b1100};  spots[17] = '{2, 161, 4'b0010};

      for (int k = 0; k < ND; k++) begin
         m_c[k] = -1;  m_addr[k] = '0;  m_front[k] = 1'b0;
      end
      for (int i = 0; i < 256; i++) flash_mem[i] = 8'hA5;

      // Clock and reset.
      rst_s = 1'b1;
      step(1'b0, 24'h0, 1'b0, 1'b0);
      rst_s  = 1'b0;
      chk_en = 1'b1;
      idle(3, 1'b0);

      // Defaults burst from 0x000150 with flash returning 0xA5.
      step(1'b1, 24'h000150, 1'b0, 1'b0);
      for (int c = 0; c <= 170; c++) begin
         scen_c = c;
         step(1'b0, 24'h0, 1'b0, 1'b0);
      end
      scen_c = -1;
      step(1'b0, 24'h0, 1'b1, 1'b0);
      pat = 8'hA5;
      for (int i = 0; i < 130; i++) begin
         for (int k = 0; k < ND; k++) begin
            o        = dut_out(k);
            got_pix  = o[1];
            want_pix = (i < 128) ? pat[7 - (i % 8)] : 1'b0;
            n_checks++;
            if (got_pix !== want_pix) begin
               n_err++;
               $display("FAIL pixel_a5 dut%0d shift%0d got=%b want=%b", k, i, got_pix, want_pix);
            end
         end
         step(1'b0, 24'h0, 1'b0, 1'b1);
      end

      // Ping-pong: fetch A, swap, fetch B while shifting A out, swap, shift B out.
      for (int i = 0; i < 256; i++) flash_mem[i] = 8'($urandom);
      step(1'b1, 24'h000010, 1'b0, 1'b0);
      idle(175, 1'b0);
      step(1'b0, 24'h0, 1'b1, 1'b0);
      step(1'b1, 24'h000090, 1'b0, 1'b1);
      idle(175, 1'b1);
      step(1'b0, 24'h0, 1'b1, 1'b0);
      idle(132, 1'b1);

      // Collisions: req and swap while busy, swap+shift, swap+req.
      step(1'b1, 24'h0A0B0C, 1'b0, 1'b0);
      for (int c = 0; c <= 172; c++)
         step((c == 12) || (c == 50), (c == 12) ? 24'hFFFFFF : 24'h123456,
              (c == 30) || (c == 100), (c % 3) == 0);
      step(1'b0, 24'h0, 1'b1, 1'b1);
      idle(5, 1'b1);
      step(1'b1, 24'h00C0DE, 1'b1, 1'b0);
      idle(175, 1'b0);
      step(1'b0, 24'h0, 1'b1, 1'b0);
      idle(130, 1'b1);

      // Reset at cycle 90, then a full burst, then back-to-back requests.
      step(1'b1, 24'h0000F0, 1'b0, 1'b0);
      idle(90, 1'b0);
      rst_s = 1'b1;
      step(1'b0, 24'h0, 1'b0, 1'b0);
      rst_s = 1'b0;
      idle(10, 1'b0);
      step(1'b1, 24'h000033, 1'b0, 1'b0);
      idle(175, 1'b0);
      step(1'b0, 24'h0, 1'b1, 1'b0);
      idle(130, 1'b1);
      step(1'b1, 24'h000044, 1'b0, 1'b0);
      idle(160, 1'b0);
      step(1'b1, 24'h000077, 1'b0, 1'b0);
      idle(175, 1'b0);
      step(1'b0, 24'h0, 1'b1, 1'b0);
      idle(130, 1'b1);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         rst_s = ($urandom_range(0, 999) == 0);
         step($urandom_range(0, 99) < 3, 24'($urandom), $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 50);
         rst_s = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_rom_burst_fetcher.md
# spi_rom_burst_fetcher

Parametrised, double-buffered SPI flash ROM burst reader for the VGA datapath. On a request it issues a READ (0x03) or FAST READ (0x0B plus dummy cycles) with a 24-bit address, and shifts BUFFER_DEPTH bits from MISO into a back buffer. In parallel, the pixel logic shifts bits out of a front buffer. A swap pulse exchanges the two buffers, so one scanline can be fetched while the previous one is displayed.

## Interface
- BUFFER_DEPTH, 128: data bits per burst; legal range ≥ 8.
- DUMMY_CYCLES, 0: 0 → command 0x03 with no dummy phase; >0 → command 0x0B followed by that many dummy cycles.
- MISO_LAG, 0: extra clk cycles between the flash driving a bit and the bit being captured; legal values 0–2.
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  single-cycle pulse that starts a burst; only accepted when busy=0.
- req_addr  in  24  flash byte address; sampled when req is accepted.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when the back buffer is complete.
- swap  in  1  exchanges the front and back buffers.
- shift_en  in  1  shifts the front buffer left by one bit.
- pixel_out  out  1  MSB of the front buffer.
- spi_cs  out  1  chip select, active HIGH (codebase convention; the pad inverts it).
- spi_sclk  out  1  ~clk, free-running.
- spi_mosi  out  1  command/address bit.
- spi_miso  in  1  flash data.

## Operation
- All logic on posedge clk. Define P = 32 + DUMMY_CYCLES and L = P + BUFFER_DEPTH + MISO_LAG.
- FSM: IDLE → CMD (8 cycles) → ADDR (24) → DUMMY (DUMMY_CYCLES, skipped when 0) → DATA (BUFFER_DEPTH + MISO_LAG) → IDLE.
- req is accepted only in IDLE. Acceptance latches req_addr and sets busy. req while busy is ignored: no state change, latched address unchanged.
- MOSI bit order:
  - CMD phase: command MSB first.
  - ADDR phase: address bits [23]..[0].
  - DUMMY and DATA phases: 0.
  - IDLE: 0.
- Capture: data bit j (j = 0..BUFFER_DEPTH−1) shifts into the back buffer LSB at the end of cycle P+j+MISO_LAG. After the burst, the first received bit sits at the MSB.
- Front buffer:
  - pixel_out = front[BUFFER_DEPTH−1].
  - shift_en shifts front left, filling with 0. Shifting more than BUFFER_DEPTH times leaves pixel_out=0.
- swap:
  - Accepted only when busy=0. It toggles the front-bank index, so the freshly fetched bits are displayed immediately.
  - swap while busy is ignored.
  - swap and shift_en in the same cycle: swap wins and no shift occurs.
  - swap and req in the same cycle: the swap happens first, and the burst fills the new back bank (the old front bank).
- Reset: spi_cs=0, spi_mosi=0, busy=0, done=0, FSM=IDLE, bank index=0, both buffers cleared (pixel_out=0). Reset mid-burst drops spi_cs at that edge, discards the partial data and does not pulse done.

## Timing
- Cycle 0 is the cycle after the req edge. From cycle 0, spi_cs=1, busy=1 and spi_mosi=cmd[7].
- spi_cs stays high for cycles 0..L−1 and is low in cycle L.
- done=1 in cycle L only. busy=0 from cycle L, so a new req may be issued in cycle L (back-to-back bursts with a 1-cycle CS-low gap).
- Total latency from req to done: L+1 clk (161 at defaults).
- The flash samples MOSI on SCLK rising = clk falling, i.e. mid-cycle, so MOSI is stable there.
- pixel_out changes on the edge after shift_en or swap.

## Test plan
- Defaults, req_addr=0x000150, flash model returns 0xA5 repeated:
  - MOSI over cycles 0..31 = 0x03000150.
  - done in cycle 160.
  - After swap, 128 shift_en pulses yield 1010_0101… on pixel_out, then 0.
- DUMMY_CYCLES=8: command 0x0B; MOSI=0 during cycles 32..39; first data bit captured at cycle 40; done at cycle 168.
- MISO_LAG=1, with a model delaying MISO by one cycle: captured buffer is identical to the MISO_LAG=0 case; spi_cs low at cycle 161.
- Ping-pong:
  - Fetch A, swap, then fetch B while shifting A out.
  - Displayed bits equal A exactly.
  - After a second swap, the displayed bits equal B.
- Collisions:
  - req at cycle 50 of a burst is ignored; address unchanged.
  - swap while busy is ignored.
  - swap+shift_en together: no shift.
  - swap+req together: the burst writes the old front bank.
- Reset at cycle 90 of a burst: spi_cs=0 and busy=0 next cycle, no done pulse, pixel_out=0; a subsequent req runs a full, correct burst.
